// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and the round-robin pick function for the three-port memory arbiter.
package mem_arb_pkg;

    localparam int NREQ       = 3;
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Search order is last+1, last+2, last; walking it backwards lets the nearest hit win.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
        logic [NREQ-1:0] g;
        logic [1:0]      sel;
        g = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sel = 2'((int'(last) + k) % NREQ);
            if (req[sel]) begin
                g      = '0;
                g[sel] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb3.sv
// Three-way grant logic: round-robin with a last-winner pointer, or fixed priority 0 > 1 > 2.
import mem_arb_pkg::*;

module rr_arb3 #(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    logic [1:0]      last;
    logic [NREQ-1:0] pick;

    always_comb begin
        if (PRIO_MODE == PRIO_FIXED)
            pick = req & (~req + NREQ'(1));
        else
            pick = rr_pick(req, last);
        gnt = rst ? '0 : pick;
    end

    // Reset value 2 makes requester 0 the first winner after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 2'd2;
        end else if (PRIO_MODE == PRIO_RR) begin
            case (gnt)
                3'b001:  last <= 2'd0;
                3'b010:  last <= 2'd1;
                3'b100:  last <= 2'd2;
                default: last <= last;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between three requesters; routes read data back
// to the granted requester one cycle later and counts contention cycles.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 4,
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic [CNT_W-1:0]         conflict_cnt
);

    logic [NREQ-1:0] rd_owner;
    logic            multi_req;

    rr_arb3 #(.PRIO_MODE(PRIO_MODE)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_we    = we[i];
                mem_addr  = addr[i*ADDR_W +: ADDR_W];
                mem_wdata = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign multi_req = ($countones(req) >= 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner     <= '0;
            conflict_cnt <= '0;
        end else begin
            rd_owner <= gnt & ~we;
            if (multi_req && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    assign rvalid = rd_owner;
    // The RAM output is only meaningful for the cycle after a read; blank it otherwise.
    assign rdata  = (|rd_owner && !rst) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiter instances (RR/16-bit count, fixed/16-bit count, RR/2-bit count)
// with shared stimulus and compares each against a behavioural model.
module tb_mem_port_arbiter;

    localparam int W  = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]      req, we;
    logic [3*AW-1:0] addr;
    logic [3*W-1:0]  wdata;

    logic [2:0]    gnt_o    [3];
    logic [2:0]    rvalid_o [3];
    logic [W-1:0]  rdata_o  [3];
    logic          mem_en_o [3];
    logic          mem_we_o [3];
    logic [AW-1:0] mem_addr_o  [3];
    logic [W-1:0]  mem_wdata_o [3];
    logic [W-1:0]  mem_rdata_i [3];
    logic [15:0]   cnt0, cnt1;
    logic [1:0]    cnt2;

    mem_port_arbiter #(.WIDTH(W), .ADDR_W(AW), .PRIO_MODE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_o[0]), .rvalid(rvalid_o[0]), .rdata(rdata_o[0]),
        .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_i[0]), .conflict_cnt(cnt0));

    mem_port_arbiter #(.WIDTH(W), .ADDR_W(AW), .PRIO_MODE(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_o[1]), .rvalid(rvalid_o[1]), .rdata(rdata_o[1]),
        .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_i[1]), .conflict_cnt(cnt1));

    mem_port_arbiter #(.WIDTH(W), .ADDR_W(AW), .PRIO_MODE(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_o[2]), .rvalid(rvalid_o[2]), .rdata(rdata_o[2]),
        .mem_en(mem_en_o[2]), .mem_we(mem_we_o[2]), .mem_addr(mem_addr_o[2]),
        .mem_wdata(mem_wdata_o[2]), .mem_rdata(mem_rdata_i[2]), .conflict_cnt(cnt2));

    // Behavioural single-port sync RAMs, reloaded from init_val whenever rst is high.
    logic [W-1:0] ram [3][16];
    logic [W-1:0] init_val [16];

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) ram[d][k] <= init_val[k];
                mem_rdata_i[d] <= '0;
            end else if (mem_en_o[d]) begin
                if (mem_we_o[d]) ram[d][mem_addr_o[d]] <= mem_wdata_o[d];
                else             mem_rdata_i[d]        <= ram[d][mem_addr_o[d]];
            end
        end
    end

    // Reference model state, one set per instance.
    int         m_last [3];
    int         m_cnt  [3];
    bit         m_pv   [3];
    int         m_po   [3];
    logic [7:0] m_pd   [3];
    logic [7:0] m_mem  [3][16];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_gnt(input int d);
        if (rst || req == 3'b000) return 3'b000;
        if (d == 1) begin
            for (int i = 0; i < 3; i++) if (req[i]) return 3'(1 << i);
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last[d] + k) % 3;
                if (req[idx]) return 3'(1 << idx);
            end
        end
        return 3'b000;
    endfunction

    function automatic int gidx(input logic [2:0] g);
        for (int i = 0; i < 3; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] cnt_of(input int d);
        if (d == 0) return 32'(cnt0);
        if (d == 1) return 32'(cnt1);
        return 32'(cnt2);
    endfunction

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            logic [2:0] g;
            int         i;
            g = exp_gnt(d);
            i = gidx(g);
            check_val($sformatf("d%0d gnt", d), 32'(gnt_o[d]), 32'(g));
            check_val($sformatf("d%0d mem_en", d), 32'(mem_en_o[d]), 32'(g != 3'b000));
            check_val($sformatf("d%0d mem_we", d), 32'(mem_we_o[d]), (i >= 0) ? 32'(we[i]) : 32'd0);
            check_val($sformatf("d%0d mem_addr", d), 32'(mem_addr_o[d]), (i >= 0) ? 32'(addr[i*AW +: AW]) : 32'd0);
            check_val($sformatf("d%0d mem_wdata", d), 32'(mem_wdata_o[d]), (i >= 0) ? 32'(wdata[i*W +: W]) : 32'd0);
            check_val($sformatf("d%0d rvalid", d), 32'(rvalid_o[d]), m_pv[d] ? 32'(1 << m_po[d]) : 32'd0);
            check_val($sformatf("d%0d rdata", d), 32'(rdata_o[d]), (rst || !m_pv[d]) ? 32'd0 : 32'(m_pd[d]));
            check_val($sformatf("d%0d conflict_cnt", d), cnt_of(d), 32'(m_cnt[d]));
        end
    endtask

    task automatic update_model();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_last[d] = 2;
                m_cnt[d]  = 0;
                m_pv[d]   = 1'b0;
                for (int k = 0; k < 16; k++) m_mem[d][k] = init_val[k];
            end else begin
                logic [2:0] g;
                int         i;
                int         a;
                int         cmax;
                g = exp_gnt(d);
                i = gidx(g);
                m_pv[d] = 1'b0;
                if (i >= 0) begin
                    a = int'(addr[i*AW +: AW]);
                    if (we[i]) begin
                        m_mem[d][a] = wdata[i*W +: W];
                    end else begin
                        m_pv[d] = 1'b1;
                        m_po[d] = i;
                        m_pd[d] = m_mem[d][a];
                    end
                    if (d != 1) m_last[d] = i;
                end
                cmax = (d == 2) ? 3 : 65535;
                if ($countones(req) >= 2 && m_cnt[d] < cmax) m_cnt[d]++;
            end
        end
    endtask

    task automatic set_in(input logic [2:0] r, input logic [2:0] w,
                          input logic [3*AW-1:0] a, input logic [3*W-1:0] wd);
        req   = r;
        we    = w;
        addr  = a;
        wdata = wd;
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(3'b000, 3'b000, '0, '0);
        settle();
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] rr_seq [6];

    initial begin
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int k = 0; k < 16; k++) init_val[k] = 8'($urandom);
        init_val[3] = 8'h5A;

        rst = 1'b1;
        set_in(3'b000, 3'b000, '0, '0);
        @(negedge clk);
        tick();

        // Reset holds the grant path idle even with all requests up.
        set_in(3'b111, 3'b000, {4'd1, 4'd2, 4'd3}, '0);
        settle();
        check_val("rst gnt", 32'(gnt_o[0]), 32'd0);
        check_val("rst mem_en", 32'(mem_en_o[0]), 32'd0);
        tick();
        rst = 1'b0;

        // Single read from requester 0
        set_in(3'b001, 3'b000, {4'd0, 4'd0, 4'd3}, '0);
        settle();
        check_val("t1 gnt", 32'(gnt_o[0]), 32'b001);
        tick();
        set_in(3'b000, 3'b000, '0, '0);
        settle();
        check_val("t1 rvalid", 32'(rvalid_o[0]), 32'b001);
        check_val("t1 rdata", 32'(rdata_o[0]), 32'h5A);
        check_val("t1 cnt", 32'(cnt0), 32'd0);
        tick();

        // Round-robin rotation with all three requesting
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_in(3'b111, 3'b000, {4'd9, 4'd8, 4'd7}, '0);
            settle();
            check_val($sformatf("rr gnt[%0d]", k), 32'(gnt_o[0]), 32'(rr_seq[k]));
            tick();
        end
        set_in(3'b000, 3'b000, '0, '0);
        settle();
        check_val("rr cnt", 32'(cnt0), 32'd6);
        tick();

        // Fixed priority starves requester 2
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(3'b110, 3'b000, {4'd2, 4'd1, 4'd0}, '0);
            settle();
            check_val($sformatf("fix gnt[%0d]", k), 32'(gnt_o[1]), 32'b010);
            tick();
        end
        set_in(3'b100, 3'b000, {4'd2, 4'd1, 4'd0}, '0);
        settle();
        check_val("fix gnt lone2", 32'(gnt_o[1]), 32'b100);
        tick();

        // Read after write to the same address
        do_reset();
        set_in(3'b001, 3'b001, {4'd0, 4'd0, 4'd7}, {8'h00, 8'h00, 8'hA5});
        settle();
        check_val("raw wr gnt", 32'(gnt_o[0]), 32'b001);
        tick();
        set_in(3'b100, 3'b000, {4'd7, 4'd0, 4'd0}, '0);
        settle();
        check_val("raw rd gnt", 32'(gnt_o[0]), 32'b100);
        check_val("raw no rvalid", 32'(rvalid_o[0]), 32'd0);
        tick();
        set_in(3'b000, 3'b000, '0, '0);
        settle();
        check_val("raw rvalid", 32'(rvalid_o[0]), 32'b100);
        check_val("raw rdata", 32'(rdata_o[0]), 32'hA5);
        tick();

        // Reset arriving while requester 1 is reading
        do_reset();
        set_in(3'b010, 3'b000, {4'd0, 4'd5, 4'd0}, '0);
        settle();
        check_val("mid gnt", 32'(gnt_o[0]), 32'b010);
        tick();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
        set_in(3'b000, 3'b000, '0, '0);
        settle();
        check_val("mid rvalid", 32'(rvalid_o[0]), 32'd0);
        tick();
        set_in(3'b111, 3'b000, {4'd1, 4'd1, 4'd1}, '0);
        settle();
        check_val("mid first gnt", 32'(gnt_o[0]), 32'b001);
        tick();

        // Counter saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(3'b011, 3'b000, {4'd0, 4'd4, 4'd4}, '0);
            settle();
            check_val($sformatf("sat cnt[%0d]", k), 32'(cnt2), (k < 3) ? 32'(k) : 32'd3);
            tick();
        end
        set_in(3'b000, 3'b000, '0, '0);
        settle();
        check_val("sat cnt end", 32'(cnt2), 32'd3);
        tick();

        // Randomised traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_in(3'($urandom), 3'($urandom), 12'($urandom), 24'($urandom));
            settle();
            tick();
        end
        rst = 1'b0;
        set_in(3'b000, 3'b000, '0, '0);
        settle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
